// File: rtl/div_3_q26.sv
// Registered signed divide-by-three for Q2.6 samples, truncating toward zero.
// Magnitude is divided by a restoring long-division chain, then the sign is reapplied.
module div_3_q26 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // One extra bit so the magnitude of the most negative code is representable.
  localparam int unsigned MAG_W = WIDTH + 1;

  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("div_3_q26: FRAC must leave room for the sign bit");
  end

  logic             neg;
  logic [MAG_W-1:0] sext;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] quo;
  logic [1:0]       rem;
  logic [2:0]       trial;
  logic [WIDTH-1:0] quo_d;

  // Sign split and magnitude.
  always_comb begin
    neg  = in[WIDTH-1];
    sext = {in[WIDTH-1], in};
    mag  = neg ? (~sext + MAG_W'(1)) : sext;
  end

  // Restoring division by 3: the running remainder never exceeds 2, so two bits suffice.
  always_comb begin
    quo   = '0;
    rem   = '0;
    trial = '0;
    for (int i = MAG_W - 1; i >= 0; i--) begin
      trial = {rem, mag[i]};
      if (trial >= 3'd3) begin
        quo[i] = 1'b1;
        rem    = 2'(trial - 3'd3);
      end else begin
        quo[i] = 1'b0;
        rem    = trial[1:0];
      end
    end
  end

  // Reapply the sign; |quotient| <= 42 so the narrowing cannot overflow.
  always_comb begin
    quo_d = WIDTH'(neg ? (~quo + MAG_W'(1)) : quo);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (en) begin
      out <= quo_d;
    end
  end

endmodule

// File: tb/tb_div_3_q26.sv
// Self-checking bench for div_3_q26: directed cases, exhaustive sweep and
// randomized enable/data against an integer-division reference.
module tb_div_3_q26;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout;

  int n_checks;
  int n_errors;

  div_3_q26 #(.WIDTH(8), .FRAC(6)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (din),
    .out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_div3(input logic [7:0] x);
    int v;
    int q;
    v = int'($signed(x));
    q = v / 3;
    return 8'(q);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_check(input string tag, input logic [7:0] x, input logic [7:0] exp);
    din = x;
    en  = 1'b1;
    step();
    check(tag, dout, exp);
  endtask

  logic [7:0] dir_in  [8];
  logic [7:0] dir_exp [8];
  logic [7:0] expected;
  logic [7:0] r;
  logic       r_en;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    en  = 1'b1;
    din = 8'h7F;
    #2;
    check("reset_async", dout, 8'h00);
    step();
    step();
    check("reset_held", dout, 8'h00);
    rst = 1'b1;

    load_check("q_0x30", 8'h30, 8'h10);
    load_check("q_0x40", 8'h40, 8'h15);

    // Enable hold: out must stay while en=0 regardless of in.
    en  = 1'b0;
    din = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en_hold", dout, 8'h15);
    end
    en = 1'b1;
    step();
    check("en_resume", dout, 8'h2A);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid", dout, 8'h00);
    step();
    check("rst_hold1", dout, 8'h00);
    step();
    check("rst_hold2", dout, 8'h00);
    rst = 1'b1;
    din = 8'hC0;
    step();
    check("rst_release", dout, 8'hEB);

    // Extremes and truncation toward zero.
    dir_in[0] = 8'h7F; dir_exp[0] = 8'h2A;
    dir_in[1] = 8'h80; dir_exp[1] = 8'hD6;
    dir_in[2] = 8'hFF; dir_exp[2] = 8'h00;
    dir_in[3] = 8'hFD; dir_exp[3] = 8'hFF;
    dir_in[4] = 8'hFE; dir_exp[4] = 8'h00;
    dir_in[5] = 8'h05; dir_exp[5] = 8'h01;
    dir_in[6] = 8'h00; dir_exp[6] = 8'h00;
    dir_in[7] = 8'h81; dir_exp[7] = 8'hD6;
    for (int i = 0; i < 8; i++) begin
      load_check($sformatf("dir_%h", dir_in[i]), dir_in[i], dir_exp[i]);
    end

    // Exhaustive sweep, one code per clock.
    for (int i = 0; i < 256; i++) begin
      r = 8'(i);
      load_check($sformatf("sweep_%h", r), r, ref_div3(r));
    end

    // Random codes with random enable; model tracks held output.
    expected = dout;
    for (int i = 0; i < 1000; i++) begin
      r    = 8'($urandom_range(255, 0));
      r_en = ($urandom_range(3, 0) != 0);
      din  = r;
      en   = r_en;
      if (r_en) expected = ref_div3(r);
      step();
      check($sformatf("rand_%0d_%h_en%0d", i, r, r_en), dout, expected);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
